// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the serial shift sequencing controller:
// FSM state encodings and the bit-counter width derivation.
package shift_ctrl_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must be able to represent 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_reg_core.sv
// Loadable bidirectional shift register; load wins over shift.
// dir = 1 moves bits toward the MSB, dir = 0 toward the LSB; zeros fill in.
module shift_reg_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            if (dir) begin
                q <= {q[WIDTH-2:0], 1'b0};
            end else begin
                q <= {1'b0, q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller: accepts a parallel word over valid/ready and
// streams it out one bit per clock, then pulses done for one cycle.
module shift_seq_ctrl
    import shift_ctrl_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    output logic             in_ready,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_en,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               order;
    logic               accept;
    logic               abort_shift;
    logic               last_bit;
    logic               sreg_load;
    logic               sreg_shift;
    logic [WIDTH-1:0]   sreg_d;
    logic [WIDTH-1:0]   sreg_q;

    assign accept      = (state == ST_IDLE) && in_valid && !abort;
    assign abort_shift = (state == ST_SHIFT) && abort;
    assign last_bit    = (cnt == LAST_CNT);

    // An abort reuses the load path with an all-zero word to clear the register.
    assign sreg_load  = accept || abort_shift;
    assign sreg_d     = accept ? in_data : '0;
    assign sreg_shift = (state == ST_SHIFT) && !abort;

    shift_reg_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (sreg_load),
        .shift (sreg_shift),
        .dir   (order),
        .d     (sreg_d),
        .q     (sreg_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counter saturates at WIDTH-1; it only marks the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            order <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            order <= msb_first;
        end else if (abort_shift) begin
            cnt <= '0;
        end else if ((state == ST_SHIFT) && !last_bit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign ser_en   = (state == ST_SHIFT);
    assign done     = (state == ST_DONE);
    assign ser_out  = ser_en && (order ? sreg_q[WIDTH-1] : sreg_q[0]);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl at WIDTH = 8.
// Expected serial sequences are written left to right as bit 0 first.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             msb_first;
    logic             abort;
    logic             in_ready;
    logic             ser_out;
    logic             ser_en;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int done_count = 0;
    int accept_cycles[$];
    int done_snap;

    shift_seq_ctrl #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .msb_first (msb_first),
        .in_ready  (in_ready),
        .abort     (abort),
        .ser_out   (ser_out),
        .ser_en    (ser_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Independent record of handshake edges and done pulses.
    always @(posedge clk) begin
        if (!rst && in_ready && in_valid && !abort) begin
            accept_cycles.push_back(cycle);
        end
        if (done) begin
            done_count <= done_count + 1;
        end
        cycle <= cycle + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic msb, input bit hold_valid);
        in_data   = data;
        msb_first = msb;
        in_valid  = 1'b1;
        step();
        if (!hold_valid) begin
            in_valid = 1'b0;
        end
    endtask

    // Entered in the first SHIFT cycle; leaves one cycle after DONE (or after abort).
    task automatic runBits(input string name, input logic [7:0] seq, input int abort_at,
                           input bit toggle, input bit abort_in_done);
        for (int k = 0; k < WIDTH; k++) begin
            checkOutput($sformatf("%s ser_en b%0d", name, k), 32'(ser_en), 32'd1);
            checkOutput($sformatf("%s ser_out b%0d", name, k), 32'(ser_out), 32'(seq[7-k]));
            checkOutput($sformatf("%s done b%0d", name, k), 32'(done), 32'd0);
            if (toggle && k == 2) begin
                msb_first = ~msb_first;
                in_data   = ~in_data;
            end
            if (k == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                checkOutput({name, " abort ser_en"}, 32'(ser_en), 32'd0);
                checkOutput({name, " abort ser_out"}, 32'(ser_out), 32'd0);
                checkOutput({name, " abort done"}, 32'(done), 32'd0);
                checkOutput({name, " abort in_ready"}, 32'(in_ready), 32'd1);
                checkOutput({name, " abort busy"}, 32'(busy), 32'd0);
                return;
            end
            step();
        end
        checkOutput({name, " done pulse"}, 32'(done), 32'd1);
        checkOutput({name, " done ser_en"}, 32'(ser_en), 32'd0);
        checkOutput({name, " done in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({name, " done busy"}, 32'(busy), 32'd1);
        if (abort_in_done) begin
            abort = 1'b1;
        end
        step();
        abort = 1'b0;
        checkOutput({name, " post done"}, 32'(done), 32'd0);
        checkOutput({name, " post in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({name, " post busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        msb_first = 1'b0;
        abort     = 1'b0;
        step();
        step();
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst ser_en", 32'(ser_en), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        rst = 1'b0;
        step();
        checkOutput("idle in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle ser_out", 32'(ser_out), 32'd0);
        checkOutput("idle ser_en", 32'(ser_en), 32'd0);
        checkOutput("idle busy", 32'(busy), 32'd0);
        checkOutput("idle done", 32'(done), 32'd0);

        // Asynchronous reset in the middle of a frame
        applyStimulus(8'hA5, 1'b1, 1'b0);
        step();
        checkOutput("pre-rst busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst busy", 32'(busy), 32'd0);
        checkOutput("async rst ser_en", 32'(ser_en), 32'd0);
        checkOutput("async rst ser_out", 32'(ser_out), 32'd0);
        checkOutput("async rst done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        checkOutput("after rst in_ready", 32'(in_ready), 32'd1);

        // 0xC1 LSB first, then MSB first with mid-frame input changes
        applyStimulus(8'hC1, 1'b0, 1'b0);
        runBits("c1_lsb", 8'b10000011, -1, 1'b0, 1'b0);
        applyStimulus(8'hC1, 1'b1, 1'b0);
        runBits("c1_msb", 8'b11000001, -1, 1'b1, 1'b0);

        // Back-to-back frames with in_valid held high
        accept_cycles.delete();
        done_snap = done_count;
        applyStimulus(8'h0F, 1'b0, 1'b1);
        in_data = 8'hF0;
        runBits("b2b_0f", 8'b11110000, -1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        runBits("b2b_f0", 8'b00001111, -1, 1'b0, 1'b0);
        checkOutput("b2b accepts", 32'(accept_cycles.size()), 32'd2);
        if (accept_cycles.size() == 2) begin
            checkOutput("b2b spacing", 32'(accept_cycles[1] - accept_cycles[0]), 32'd10);
        end
        checkOutput("b2b done count", 32'(done_count - done_snap), 32'd2);

        // Abort during the 4th bit, then a clean frame
        done_snap = done_count;
        applyStimulus(8'hFF, 1'b0, 1'b0);
        runBits("abort_ff", 8'b11111111, 3, 1'b0, 1'b0);
        checkOutput("abort no done", 32'(done_count - done_snap), 32'd0);
        applyStimulus(8'h01, 1'b1, 1'b0);
        runBits("after_abort_01", 8'b00000001, -1, 1'b0, 1'b0);

        // Abort together with in_valid in IDLE blocks the accept
        in_data  = 8'h55;
        in_valid = 1'b1;
        abort    = 1'b1;
        step();
        checkOutput("idle abort in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle abort busy", 32'(busy), 32'd0);
        step();
        checkOutput("idle abort ser_en", 32'(ser_en), 32'd0);
        in_valid = 1'b0;
        abort    = 1'b0;

        // Abort in DONE is ignored
        done_snap = done_count;
        applyStimulus(8'h3C, 1'b0, 1'b0);
        runBits("done_abort_3c", 8'b00111100, -1, 1'b0, 1'b1);
        checkOutput("done abort count", 32'(done_count - done_snap), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
